// File: rtl/pipe_adder_pkg.sv
// Shared op encoding for the pipelined adder and the ALU decoder.
package pipe_adder_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD  = 2'b00;
    localparam op_t OP_SUB  = 2'b01;
    localparam op_t OP_ADDC = 2'b10;
    localparam op_t OP_SUBB = 2'b11;

    // Carry into bit 0: fixed 0/1 for ADD/SUB, external cin for ADDC/SUBB.
    function automatic logic carry_sel(input op_t op, input logic cin);
        return op[1] ? cin : op[0];
    endfunction

    function automatic logic invert_b(input op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// One SW-bit slice of the split carry chain, with a slice-is-zero flag.
module pipe_adder_slice #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          zero
);

    logic [SW:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    assign s    = full[SW-1:0];
    assign cout = full[SW];
    assign zero = ~|full[SW-1:0];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/sub: the carry chain is cut into STAGES registered slices,
// each stage with its own valid bit and a collapsing-bubble handshake.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    logic [STAGES-1:0] v_q, v_d, en;
    logic [STAGES:0]   ld;

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] r_in [STAGES];
    logic             cin_s [STAGES];
    logic             z_in [STAGES];

    logic [SW-1:0]    s_sl [STAGES];
    logic             c_d [STAGES];
    logic             z_sl [STAGES];

    logic [WIDTH-1:0] r_d [STAGES];
    logic             z_d [STAGES];
    logic             o_d [STAGES];

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic             c_q [STAGES];
    logic             z_q [STAGES];
    logic             o_q [STAGES];

    // A stage loads when it is empty or the stage after it loads; the last
    // stage drains on out_ready. in_ready therefore never depends on in_valid.
    always_comb begin
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = ~v_q[k] | ld[k+1];
        end
        en[0]  = ld[0] & in_valid;
        v_d[0] = ld[0] ? in_valid : v_q[0];
        for (int k = 1; k < STAGES; k++) begin
            en[k]  = ld[k] & v_q[k-1];
            v_d[k] = ld[k] ? v_q[k-1] : v_q[k];
        end
    end

    always_comb begin
        a_d[0]   = a;
        b_d[0]   = invert_b(op) ? ~b : b;
        cin_s[0] = carry_sel(op, cin);
        r_in[0]  = '0;
        z_in[0]  = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            cin_s[k] = c_q[k-1];
            r_in[k]  = r_q[k-1];
            z_in[k]  = z_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        pipe_adder_slice #(.SW(SW)) u_slice (
            .a    (a_d[k][k*SW +: SW]),
            .b    (b_d[k][k*SW +: SW]),
            .cin  (cin_s[k]),
            .s    (s_sl[k]),
            .cout (c_d[k]),
            .zero (z_sl[k])
        );
    end

    // Overflow is only meaningful once the top slice has been added, i.e. in
    // the last stage; earlier stages compute it but it is overwritten later.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            r_d[k]               = r_in[k];
            r_d[k][k*SW +: SW]   = s_sl[k];
            z_d[k]               = z_in[k] & z_sl[k];
            o_d[k]               = (a_d[k][WIDTH-1] == b_d[k][WIDTH-1]) &&
                                   (r_d[k][WIDTH-1] != a_d[k][WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
                z_q[k] <= 1'b0;
                o_q[k] <= 1'b0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    r_q[k] <= r_d[k];
                    c_q[k] <= c_d[k];
                    z_q[k] <= z_d[k];
                    o_q[k] <= o_d[k];
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = r_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = o_q[STAGES-1];
    assign zero      = z_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: directed corner cases, back-pressure and
// mid-stream reset, plus a random sweep against a whole-word reference model.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    parameter int WIDTH  = 32;
    parameter int STAGES = 2;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } res_t;

    logic             clk, rst_n;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] a, b, sum;
    logic [1:0]       op;
    logic             cin, cout, ovf, zero;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   occ   = 0;
    logic prev_stall = 1'b0;
    res_t prev_out;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o, input logic z);
        res_t r;
        r.sum  = s;
        r.cout = c;
        r.ovf  = o;
        r.zero = z;
        return r;
    endfunction

    function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic [1:0] mop, input logic mcin);
        logic [WIDTH-1:0] be;
        logic             ci;
        logic [WIDTH:0]   f;
        case (mop)
            OP_ADD:  begin be = mb;  ci = 1'b0; end
            OP_SUB:  begin be = ~mb; ci = 1'b1; end
            OP_ADDC: begin be = mb;  ci = mcin; end
            default: begin be = ~mb; ci = mcin; end
        endcase
        f = {1'b0, ma} + {1'b0, be} + {{WIDTH{1'b0}}, ci};
        return mk(f[WIDTH-1:0], f[WIDTH],
                  (ma[WIDTH-1] == be[WIDTH-1]) && (f[WIDTH-1] != ma[WIDTH-1]),
                  f[WIDTH-1:0] == '0);
    endfunction

    // One clock of stimulus; scoreboard pop/compare on every output transfer.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic [1:0] iop, input logic icin, input res_t iexp,
                         input logic ordy, input logic chk_rdy,
                         output logic acc, output logic got, output res_t obs);
        res_t e;
        logic exp_rdy;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        op        = iop;
        cin       = icin;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        got = out_valid && out_ready;
        obs = {sum, cout, ovf, zero};
        if (chk_rdy) begin
            exp_rdy = (occ < STAGES) || ordy;
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL in_ready: got %b want %b (occupancy %0d)", in_ready, exp_rdy, occ);
            end
        end
        if (prev_stall && out_valid) begin
            n_cmp++;
            if (obs !== prev_out) begin
                n_err++;
                $display("FAIL stall_stable: got %h want %h", obs, prev_out);
            end
        end
        if (got) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %h want no output", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL result: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                             obs.sum, obs.cout, obs.ovf, obs.zero, e.sum, e.cout, e.ovf, e.zero);
                end
            end
        end
        if (acc) exp_q.push_back(iexp);
        occ        = occ + int'(acc) - int'(got);
        prev_stall = out_valid && !out_ready;
        prev_out   = obs;
        @(posedge clk);
    endtask

    task automatic idle(input logic ordy, output logic got, output res_t obs);
        logic acc;
        cycle(1'b0, '0, '0, OP_ADD, 1'b0, '0, ordy, 1'b1, acc, got, obs);
    endtask

    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic [1:0] iop, input logic icin, input res_t e);
        logic acc, got;
        res_t obs;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++)
            cycle(1'b1, ia, ib, iop, icin, e, 1'b1, 1'b1, acc, got, obs);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: got in_ready=%b want accept within 20 cycles", in_ready);
        end
    endtask

    task automatic drain();
        logic got;
        res_t obs;
        for (int i = 0; i < 50 && occ != 0; i++) idle(1'b1, got, obs);
        n_cmp++;
        if (occ != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d in flight, %0d pending want 0", occ, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = OP_ADD; cin = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp += 6;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (sum !== '0)         begin n_err++; $display("FAIL rst_sum: got %h want 0", sum); end
        if (cout !== 1'b0)      begin n_err++; $display("FAIL rst_cout: got %b want 0", cout); end
        if (ovf !== 1'b0)       begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        if (zero !== 1'b0)      begin n_err++; $display("FAIL rst_zero: got %b want 0", zero); end
        exp_q.delete(); occ = 0; prev_stall = 1'b0;
    endtask

    task automatic test_latency();
        logic acc, got;
        res_t obs;
        int   lat;
        cycle(1'b1, 32'h5, 32'h3, OP_ADD, 1'b0, mk(32'h8, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, acc, got, obs);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            idle(1'b1, got, obs);
            if (got) lat = i;
        end
        n_cmp += 2;
        if (!acc || lat != STAGES) begin
            n_err++;
            $display("FAIL latency: got %0d cycles (accepted=%b) want %0d", lat, acc, STAGES);
        end
        if (obs.sum !== 32'h8) begin
            n_err++;
            $display("FAIL add_5_3: got %h want 00000008", obs.sum);
        end
        drain();
    endtask

    task automatic test_add_wrap();
        issue(32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
        issue(32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        drain();
    endtask

    task automatic test_sub();
        issue(32'h5, 32'h5, OP_SUB, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
        issue(32'h0, 32'h1, OP_SUB, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
        issue(32'h10, 32'h3, OP_SUBB, 1'b0, mk(32'hC, 1'b1, 1'b0, 1'b0));
        drain();
    endtask

    task automatic test_chain();
        logic got, seen, c_lo;
        res_t obs;
        issue(32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
        seen = 1'b0;
        c_lo = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            idle(1'b1, got, obs);
            if (got) begin seen = 1'b1; c_lo = obs.cout; end
        end
        n_cmp++;
        if (!seen || c_lo !== 1'b1) begin
            n_err++;
            $display("FAIL chain_low_cout: got %b (seen=%b) want 1", c_lo, seen);
        end
        issue(32'h0, 32'h0, OP_ADDC, c_lo, mk(32'h1, 1'b0, 1'b0, 1'b0));
        drain();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] av [8];
        logic [WIDTH-1:0] bv [8];
        logic acc, got, ordy;
        res_t obs;
        int   sent, rcvd, cyc, idx;
        for (int i = 0; i < 8; i++) begin
            av[i] = $urandom();
            bv[i] = $urandom();
        end
        sent = 0; rcvd = 0; cyc = 0;
        while ((sent < 8 || rcvd < 8) && cyc < 200) begin
            ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
            idx  = (sent < 8) ? sent : 7;
            cycle(sent < 8, av[idx], bv[idx], OP_ADD, 1'b0,
                  model(av[idx], bv[idx], OP_ADD, 1'b0), ordy, 1'b1, acc, got, obs);
            if (acc) sent++;
            if (got) rcvd++;
            cyc++;
        end
        n_cmp++;
        if (rcvd != 8 || sent != 8) begin
            n_err++;
            $display("FAIL b2b_count: got sent=%0d rcvd=%0d want 8/8", sent, rcvd);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        logic acc, got;
        res_t obs;
        cycle(1'b1, 32'h11, 32'h22, OP_ADD, 1'b0, mk(32'h33, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, acc, got, obs);
        cycle(1'b1, 32'h44, 32'h55, OP_ADD, 1'b0, mk(32'h99, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, acc, got, obs);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_out_valid: got %b want 0", out_valid);
        end
        exp_q.delete(); occ = 0; prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle(1'b1, got, obs);
            n_cmp++;
            if (got !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_stale: got out_valid=%b sum=%h want no output", got, obs.sum);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra, rb;
        logic [1:0] rop;
        logic rc, acc, got, ordy;
        res_t obs;
        for (int n = 0; n < 40; n++) begin
            ra  = (n % 5 == 0) ? {1'b0, {(WIDTH-1){1'b1}}} : $urandom();
            rb  = (n % 7 == 0) ? '1 : $urandom();
            rop = 2'($urandom_range(0, 3));
            rc  = 1'($urandom_range(0, 1));
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) begin
                ordy = ($urandom_range(0, 3) != 0);
                cycle(1'b1, ra, rb, rop, rc, model(ra, rb, rop, rc), ordy, 1'b1, acc, got, obs);
            end
            if (!acc) begin
                n_cmp++;
                n_err++;
                $display("FAIL random_accept: got no accept want accept within 40 cycles");
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_add_wrap();
        test_sub();
        test_chain();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
